wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline writeback

---
 rtl/cpu_pkg.sv | 14 +
 rtl/wb_port_arbiter.sv | 111 +++++++++++
 tb/tb_wb_port_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the writeback port arbiter state encoding.
package cpu_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_URGENT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between the pipeline writeback path and the MDU.
// The pipeline has priority; a starvation guard forces the MDU through after MAX_WAIT blocked cycles.
module wb_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pipe_valid,
    input  logic [REG_AW-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_ready,
    input  logic              mdu_valid,
    input  logic [REG_AW-1:0] mdu_waddr,
    input  logic [DATA_W-1:0] mdu_wdata,
    output logic              mdu_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mdu_urgent
);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_pw;
    logic              w_mw;
    logic              w_pipe_ready;
    logic              w_mdu_ready;
    logic              w_pipe_win;
    logic              w_we;
    logic              w_mdu_blocked;

    assign w_pw = pipe_valid && (pipe_waddr != REG_ZERO);
    assign w_mw = mdu_valid && (mdu_waddr != REG_ZERO);

    // Same nonzero destination lets both sides complete; the younger pipe write wins the data.
    always_comb begin
        w_pipe_ready = 1'b1;
        w_mdu_ready  = 1'b0;
        if (resetn) begin
            if (r_state == ARB_NORMAL) begin
                w_mdu_ready = !w_pw || (mdu_waddr == pipe_waddr);
            end else begin
                w_mdu_ready  = 1'b1;
                w_pipe_ready = !w_pw || (pipe_waddr == mdu_waddr);
            end
        end
    end

    assign w_pipe_win    = w_pw && w_pipe_ready;
    assign w_we          = w_pipe_win || (w_mw && w_mdu_ready);
    assign w_mdu_blocked = mdu_valid && !w_mdu_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ARB_NORMAL;
            r_wait_cnt <= '0;
        end else begin
            if (w_mdu_blocked) begin
                if (r_wait_cnt != '1) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end

            case (r_state)
                ARB_NORMAL: begin
                    if (w_mdu_blocked && (r_wait_cnt == CNT_W'(MAX_WAIT - 1))) begin
                        r_state <= ARB_URGENT;
                    end
                end
                // MDU is always ready here, so URGENT lasts one cycle whether or not it is still valid.
                ARB_URGENT: begin
                    r_state <= ARB_NORMAL;
                end
                default: begin
                    r_state <= ARB_NORMAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_we;
            if (w_we) begin
                r_rf_waddr <= w_pipe_win ? pipe_waddr : mdu_waddr;
                r_rf_wdata <= w_pipe_win ? pipe_wdata : mdu_wdata;
            end
        end
    end

    assign pipe_ready = w_pipe_ready;
    assign mdu_ready  = w_mdu_ready;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign mdu_urgent = (r_state == ARB_URGENT);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter: reset, priority, starvation guard, WAW and $0 cases.
module tb_wb_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        pipe_valid;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_ready;
    logic        mdu_valid;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mdu_urgent;

    int n_tests = 0;
    int n_fail  = 0;

    wb_port_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pipe_valid (pipe_valid),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .pipe_ready (pipe_ready),
        .mdu_valid  (mdu_valid),
        .mdu_waddr  (mdu_waddr),
        .mdu_wdata  (mdu_wdata),
        .mdu_ready  (mdu_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .mdu_urgent (mdu_urgent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        pipe_valid = pv; pipe_waddr = pa; pipe_wdata = pd;
        mdu_valid  = mv; mdu_waddr  = ma; mdu_wdata  = md;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
        @(posedge clk); #1;
        n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL reset_pre_we: got %b exp 1", rf_we); end
        #2 resetn = 1'b0;
        #1;
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_async_we: got %b exp 0", rf_we); end
        n_tests++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_addr_data: got %0d/%h exp 0/0", rf_waddr, rf_wdata); end
        n_tests++; if (pipe_ready !== 1'b1 || mdu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got p%b m%b exp p1 m0", pipe_ready, mdu_ready); end
        n_tests++; if (mdu_urgent !== 1'b0) begin n_fail++; $display("FAIL reset_urgent: got %b exp 0", mdu_urgent); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (pipe_ready !== 1'b1 || mdu_urgent !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got p%b u%b we%b exp p1 u0 we0", pipe_ready, mdu_urgent, rf_we); end
        n_tests++; if (dut.r_wait_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_wait_cnt: got %0d exp 0", dut.r_wait_cnt); end
    endtask

    task automatic test_pipe_only();
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        #1;
        n_tests++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL pipe_only_ready: got %b exp 1", pipe_ready); end
        @(posedge clk); #1;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            n_fail++; $display("FAIL pipe_only_write: got we%b %0d/%h exp we1 5/1234", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        n_tests++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            n_fail++; $display("FAIL pipe_only_hold: got we%b %0d/%h exp we0 5/1234", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 32'h11 * i, 1'b0, 5'd0, 32'd0);
            @(posedge clk); #1;
            n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== 32'h11 * i) begin
                n_fail++; $display("FAIL b2b_%0d: got we%b %0d/%h exp we1 %0d/%h", i, rf_we, rf_waddr, rf_wdata, i, 32'h11 * i); end
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_contention();
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++; if (mdu_ready !== 1'b0 || pipe_ready !== 1'b1 || mdu_urgent !== 1'b0) begin
                n_fail++; $display("FAIL contend_block_%0d: got m%b p%b u%b exp m0 p1 u0", c, mdu_ready, pipe_ready, mdu_urgent); end
            @(posedge clk); #1;
            n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
                n_fail++; $display("FAIL contend_pipe_wr_%0d: got we%b %0d exp we1 3", c, rf_we, rf_waddr); end
            @(negedge clk);
        end
        #1;
        n_tests++; if (mdu_urgent !== 1'b1 || mdu_ready !== 1'b1 || pipe_ready !== 1'b0) begin
            n_fail++; $display("FAIL contend_urgent: got u%b m%b p%b exp u1 m1 p0", mdu_urgent, mdu_ready, pipe_ready); end
        @(posedge clk); #1;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77 || mdu_urgent !== 1'b0) begin
            n_fail++; $display("FAIL contend_mdu_wr: got we%b %0d/%h u%b exp we1 7/77 u0", rf_we, rf_waddr, rf_wdata, mdu_urgent); end
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        #1;
        n_tests++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL contend_pipe_resume: got %b exp 1", pipe_ready); end
        @(posedge clk); #1;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
            n_fail++; $display("FAIL contend_after: got we%b %0d exp we1 3", rf_we, rf_waddr); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_waw();
        @(negedge clk);
        drive(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
        #1;
        n_tests++; if (pipe_ready !== 1'b1 || mdu_ready !== 1'b1) begin
            n_fail++; $display("FAIL waw_ready: got p%b m%b exp p1 m1", pipe_ready, mdu_ready); end
        @(posedge clk); #1;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hA) begin
            n_fail++; $display("FAIL waw_write: got we%b %0d/%h exp we1 9/a", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        n_tests++; if (rf_we !== 1'b0 || rf_wdata !== 32'hA) begin
            n_fail++; $display("FAIL waw_single: got we%b %h exp we0 a", rf_we, rf_wdata); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd4, 32'h44);
        #1;
        n_tests++; if (mdu_ready !== 1'b1 || pipe_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_ready: got m%b p%b exp m1 p1", mdu_ready, pipe_ready); end
        @(posedge clk); #1;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin
            n_fail++; $display("FAIL zero_mdu_wr: got we%b %0d/%h exp we1 4/44", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        #1;
        n_tests++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL zero_pipe_ready: got %b exp 1", pipe_ready); end
        @(posedge clk); #1;
        n_tests++; if (rf_we !== 1'b0 || rf_wdata !== 32'h44) begin
            n_fail++; $display("FAIL zero_no_write: got we%b %h exp we0 44", rf_we, rf_wdata); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_idle_urgent();
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
        repeat (4) @(negedge clk);
        #1;
        n_tests++; if (mdu_urgent !== 1'b1) begin n_fail++; $display("FAIL idle_urg_enter: got %b exp 1", mdu_urgent); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        n_tests++; if (mdu_urgent !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL idle_urg_exit: got u%b we%b exp u0 we0", mdu_urgent, rf_we); end
        n_tests++; if (dut.r_wait_cnt !== 3'd0) begin n_fail++; $display("FAIL idle_urg_cnt: got %0d exp 0", dut.r_wait_cnt); end
    endtask

    initial begin
        resetn = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        test_reset();
        test_pipe_only();
        test_back_to_back();
        test_contention();
        test_waw();
        test_zero_reg();
        test_idle_urgent();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1);
    end

endmodule
